// File: rtl/core_pkg.sv
// rtl/core_pkg.sv - shared encodings for the core memory port and hazard control
package core_pkg;

    // Memory port FSM states
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUSY = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    // Owner of the access currently in flight
    localparam logic [1:0] O_NONE = 2'd0;
    localparam logic [1:0] O_IF   = 2'd1;
    localparam logic [1:0] O_MEM  = 2'd2;

    // Pipe-control codes merged by hazard control
    localparam logic [1:0] C_PIPE  = 2'd0;
    localparam logic [1:0] C_STALL = 2'd1;
    localparam logic [1:0] C_FLUSH = 2'd2;

    // Collapse a stall/flush pair into one pipe-control code; flush dominates
    function automatic logic [1:0] pipe_ctl(input logic stall, input logic flush);
        if (flush)
            return C_FLUSH;
        else if (stall)
            return C_STALL;
        else
            return C_PIPE;
    endfunction

endpackage

// File: rtl/mem_port_arbiter_arb2_rr.sv
// rtl/mem_port_arbiter_arb2_rr.sv - two-requester grant, MEM priority alternating on contention
module arb2_rr (
    input  logic clk,
    input  logic rst,
    input  logic i_req_mem,
    input  logic i_req_if,
    input  logic i_update,
    output logic o_gnt_mem,
    output logic o_gnt_if
);

    logic r_last_mem;

    // Lone requester wins; on contention MEM wins unless it won the previous grant
    always_comb begin
        o_gnt_mem = 1'b0;
        o_gnt_if  = 1'b0;
        if (i_req_mem && i_req_if) begin
            if (r_last_mem)
                o_gnt_if = 1'b1;
            else
                o_gnt_mem = 1'b1;
        end else begin
            o_gnt_mem = i_req_mem;
            o_gnt_if  = i_req_if;
        end
    end

    // Remember who took the most recent grant
    always_ff @(posedge clk) begin
        if (!rst)
            r_last_mem <= 1'b0;
        else if (i_update)
            r_last_mem <= o_gnt_mem;
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - shares one single-port memory between fetch and load/store
module mem_port_arbiter
    import core_pkg::*;
#(
    parameter int DWIDTH  = 32,
    parameter int MEM_LAT = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [DWIDTH-1:0] if_addr,
    input  logic              if_kill,
    output logic [DWIDTH-1:0] if_rdata,
    output logic              if_ack,
    output logic              if_stall,
    input  logic              mem_req,
    input  logic              mem_we,
    input  logic [DWIDTH-1:0] mem_addr,
    input  logic [DWIDTH-1:0] mem_wdata,
    output logic [DWIDTH-1:0] mem_rdata,
    output logic              mem_ack,
    output logic              mem_stall,
    output logic              m_en,
    output logic              m_we,
    output logic [DWIDTH-1:0] m_addr,
    output logic [DWIDTH-1:0] m_wdata,
    input  logic [DWIDTH-1:0] m_rdata
);

    localparam logic [3:0] LAT = 4'(MEM_LAT);

    logic [1:0]        r_state;
    logic [3:0]        r_cnt;
    logic [1:0]        r_owner;
    logic              r_kill_pend;
    logic [DWIDTH-1:0] r_if_rdata;
    logic [DWIDTH-1:0] r_mem_rdata;

    logic w_resp;
    logic w_open;
    logic w_if_elig;
    logic w_mem_elig;
    logic w_gnt_if;
    logic w_gnt_mem;
    logic w_gnt;
    logic w_rd_done;

    // Acks, stalls and grant eligibility; a requester being acked cannot re-win this cycle
    always_comb begin
        w_resp     = (r_state == S_RESP);
        if_ack     = rst && w_resp && (r_owner == O_IF) && !r_kill_pend && !if_kill;
        mem_ack    = rst && w_resp && (r_owner == O_MEM);
        if_stall   = if_req && !if_ack;
        mem_stall  = mem_req && !mem_ack;
        w_open     = rst && ((r_state == S_IDLE) || w_resp);
        w_mem_elig = w_open && mem_req && !mem_ack;
        w_if_elig  = w_open && if_req && !if_kill && !if_ack;
        w_rd_done  = (r_state == S_BUSY) && (r_cnt == LAT);
    end

    arb2_rr u_arb (
        .clk       (clk),
        .rst       (rst),
        .i_req_mem (w_mem_elig),
        .i_req_if  (w_if_elig),
        .i_update  (w_gnt),
        .o_gnt_mem (w_gnt_mem),
        .o_gnt_if  (w_gnt_if)
    );

    // Memory command is issued in the grant cycle only, from the winner
    always_comb begin
        w_gnt   = w_gnt_mem || w_gnt_if;
        m_en    = w_gnt;
        m_we    = w_gnt_mem && mem_we;
        m_addr  = '0;
        m_wdata = '0;
        if (w_gnt_mem) begin
            m_addr  = mem_addr;
            m_wdata = mem_wdata;
        end else if (w_gnt_if) begin
            m_addr  = if_addr;
        end
    end

    // Access sequencer: grant in IDLE/RESP, count read latency in BUSY, ack in RESP
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state     <= S_IDLE;
            r_cnt       <= 4'd0;
            r_owner     <= O_NONE;
            r_kill_pend <= 1'b0;
        end else begin
            case (r_state)
                S_BUSY: begin
                    if (if_kill && (r_owner == O_IF))
                        r_kill_pend <= 1'b1;
                    if (r_cnt == LAT) begin
                        r_state <= S_RESP;
                        r_cnt   <= 4'd0;
                    end else begin
                        r_cnt   <= r_cnt + 4'd1;
                    end
                end
                default: begin
                    r_kill_pend <= 1'b0;
                    if (w_gnt) begin
                        r_owner <= w_gnt_mem ? O_MEM : O_IF;
                        if (w_gnt_mem && mem_we) begin
                            r_state <= S_RESP;
                            r_cnt   <= 4'd0;
                        end else begin
                            r_state <= S_BUSY;
                            r_cnt   <= 4'd1;
                        end
                    end else begin
                        r_state <= S_IDLE;
                        r_owner <= O_NONE;
                        r_cnt   <= 4'd0;
                    end
                end
            endcase
        end
    end

    // Capture read data at the end of the latency window; killed fetches leave if_rdata alone
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_if_rdata  <= '0;
            r_mem_rdata <= '0;
        end else if (w_rd_done) begin
            if (r_owner == O_MEM)
                r_mem_rdata <= m_rdata;
            else if ((r_owner == O_IF) && !r_kill_pend && !if_kill)
                r_if_rdata  <= m_rdata;
        end
    end

    assign if_rdata  = r_if_rdata;
    assign mem_rdata = r_mem_rdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - directed self-checking bench for mem_port_arbiter
module tb_mem_port_arbiter;

    logic        clk;
    logic        rst;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_kill;
    logic [31:0] if_rdata;
    logic        if_ack;
    logic        if_stall;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ack;
    logic        mem_stall;
    logic        m_en;
    logic        m_we;
    logic [31:0] m_addr;
    logic [31:0] m_wdata;
    logic [31:0] m_rdata;

    int total;
    int bad;

    logic [31:0] tb_mem [0:255];
    logic [7:0]  rd_a1;

    mem_port_arbiter #(.DWIDTH(32), .MEM_LAT(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_kill   (if_kill),
        .if_rdata  (if_rdata),
        .if_ack    (if_ack),
        .if_stall  (if_stall),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ack   (mem_ack),
        .mem_stall (mem_stall),
        .m_en      (m_en),
        .m_we      (m_we),
        .m_addr    (m_addr),
        .m_wdata   (m_wdata),
        .m_rdata   (m_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Two-cycle memory: address sampled at the m_en edge, data valid in cycle t+2
    always @(posedge clk) begin
        if (!rst) begin
            tb_mem[16]  <= 32'hDEADBEEF;
            tb_mem[17]  <= 32'h11112222;
            tb_mem[18]  <= 32'h33334444;
            tb_mem[32]  <= 32'h55556666;
            tb_mem[64]  <= 32'hA5A50001;
            tb_mem[128] <= 32'h00000000;
        end else if (m_en && m_we) begin
            tb_mem[m_addr[9:2]] <= m_wdata;
        end
        rd_a1   <= m_addr[9:2];
        m_rdata <= tb_mem[rd_a1];
    end

    task automatic idle_inputs();
        if_req = 0; if_addr = 0; if_kill = 0;
        mem_req = 0; mem_we = 0; mem_addr = 0; mem_wdata = 0;
    endtask

    task automatic next_cycle();
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst = 0; if_req = 1; if_addr = 32'h40; if_kill = 0;
        mem_req = 1; mem_we = 1; mem_addr = 32'h100; mem_wdata = 32'hFFFF0000;
        next_cycle();
        next_cycle();
        #4;
        total++; if (m_en !== 1'b0) begin bad++; $display("FAIL reset_m_en got=%b exp=0", m_en); end
        total++; if (m_we !== 1'b0) begin bad++; $display("FAIL reset_m_we got=%b exp=0", m_we); end
        total++; if (m_addr !== 32'h0) begin bad++; $display("FAIL reset_m_addr got=%h exp=0", m_addr); end
        total++; if (m_wdata !== 32'h0) begin bad++; $display("FAIL reset_m_wdata got=%h exp=0", m_wdata); end
        total++; if (if_ack !== 1'b0 || mem_ack !== 1'b0) begin bad++; $display("FAIL reset_acks got=%b%b exp=00", if_ack, mem_ack); end
        total++; if (if_rdata !== 32'h0 || mem_rdata !== 32'h0) begin bad++; $display("FAIL reset_rdata got=%h/%h exp=0/0", if_rdata, mem_rdata); end
        next_cycle();
        rst = 1;
        idle_inputs();
        next_cycle();
    endtask

    task automatic test_lone_fetch();
        for (int c = 0; c <= 3; c++) begin
            if_req = 1; if_addr = 32'h40;
            #4;
            total++; if (m_en !== (c == 0)) begin bad++; $display("FAIL fetch_m_en c=%0d got=%b exp=%b", c, m_en, (c == 0)); end
            total++; if (if_ack !== (c == 3)) begin bad++; $display("FAIL fetch_ack c=%0d got=%b exp=%b", c, if_ack, (c == 3)); end
            total++; if (if_stall !== (c != 3)) begin bad++; $display("FAIL fetch_stall c=%0d got=%b exp=%b", c, if_stall, (c != 3)); end
            if (c == 0) begin
                total++; if (m_addr !== 32'h40 || m_we !== 1'b0) begin bad++; $display("FAIL fetch_cmd got=%h/%b exp=00000040/0", m_addr, m_we); end
            end
            if (c == 3) begin
                total++; if (if_rdata !== 32'hDEADBEEF) begin bad++; $display("FAIL fetch_rdata got=%h exp=deadbeef", if_rdata); end
            end
            next_cycle();
        end
        idle_inputs();
        next_cycle();
    endtask

    task automatic test_simultaneous();
        for (int c = 0; c <= 6; c++) begin
            if_req = (c <= 6); if_addr = 32'h44;
            mem_req = (c <= 3); mem_we = 0; mem_addr = 32'h100;
            #4;
            total++; if (m_en !== (c == 0 || c == 3)) begin bad++; $display("FAIL simul_m_en c=%0d got=%b exp=%b", c, m_en, (c == 0 || c == 3)); end
            total++; if (mem_ack !== (c == 3)) begin bad++; $display("FAIL simul_mem_ack c=%0d got=%b exp=%b", c, mem_ack, (c == 3)); end
            total++; if (if_ack !== (c == 6)) begin bad++; $display("FAIL simul_if_ack c=%0d got=%b exp=%b", c, if_ack, (c == 6)); end
            if (c == 0) begin
                total++; if (m_addr !== 32'h100) begin bad++; $display("FAIL simul_addr0 got=%h exp=00000100", m_addr); end
            end
            if (c == 3) begin
                total++; if (m_addr !== 32'h44) begin bad++; $display("FAIL simul_addr3 got=%h exp=00000044", m_addr); end
                total++; if (mem_rdata !== 32'hA5A50001) begin bad++; $display("FAIL simul_mem_rdata got=%h exp=a5a50001", mem_rdata); end
            end
            if (c == 6) begin
                total++; if (if_rdata !== 32'h11112222) begin bad++; $display("FAIL simul_if_rdata got=%h exp=11112222", if_rdata); end
            end
            next_cycle();
        end
        idle_inputs();
        next_cycle();
    endtask

    task automatic test_store();
        for (int c = 0; c <= 5; c++) begin
            mem_req = 1; mem_we = (c <= 1); mem_addr = 32'h200; mem_wdata = 32'h12345678;
            #4;
            total++; if (m_en !== (c == 0 || c == 2)) begin bad++; $display("FAIL store_m_en c=%0d got=%b exp=%b", c, m_en, (c == 0 || c == 2)); end
            total++; if (mem_ack !== (c == 1 || c == 5)) begin bad++; $display("FAIL store_ack c=%0d got=%b exp=%b", c, mem_ack, (c == 1 || c == 5)); end
            if (c == 0) begin
                total++; if (m_we !== 1'b1 || m_addr !== 32'h200 || m_wdata !== 32'h12345678) begin bad++; $display("FAIL store_cmd got=%b/%h/%h exp=1/00000200/12345678", m_we, m_addr, m_wdata); end
            end
            if (c == 1) begin
                total++; if (mem_rdata !== 32'hA5A50001) begin bad++; $display("FAIL store_rdata_hold got=%h exp=a5a50001", mem_rdata); end
            end
            if (c == 2) begin
                total++; if (m_we !== 1'b0 || m_addr !== 32'h200) begin bad++; $display("FAIL store_load_cmd got=%b/%h exp=0/00000200", m_we, m_addr); end
            end
            if (c == 5) begin
                total++; if (mem_rdata !== 32'h12345678) begin bad++; $display("FAIL store_readback got=%h exp=12345678", mem_rdata); end
            end
            next_cycle();
        end
        idle_inputs();
        next_cycle();
    endtask

    task automatic test_fetch_kill();
        for (int c = 0; c <= 6; c++) begin
            if_req = 1; if_kill = (c == 1);
            if_addr = (c <= 1) ? 32'h48 : 32'h80;
            #4;
            total++; if (if_ack !== (c == 6)) begin bad++; $display("FAIL kill_ack c=%0d got=%b exp=%b", c, if_ack, (c == 6)); end
            total++; if (m_en !== (c == 0 || c == 3)) begin bad++; $display("FAIL kill_m_en c=%0d got=%b exp=%b", c, m_en, (c == 0 || c == 3)); end
            if (c == 3) begin
                total++; if (m_addr !== 32'h80) begin bad++; $display("FAIL kill_regrant_addr got=%h exp=00000080", m_addr); end
                total++; if (if_rdata !== 32'h11112222) begin bad++; $display("FAIL kill_rdata_hold got=%h exp=11112222", if_rdata); end
            end
            if (c == 6) begin
                total++; if (if_rdata !== 32'h55556666) begin bad++; $display("FAIL kill_new_rdata got=%h exp=55556666", if_rdata); end
            end
            next_cycle();
        end
        idle_inputs();
        next_cycle();
    endtask

    task automatic test_back_to_back();
        for (int c = 0; c <= 12; c++) begin
            if_req = (c <= 9); if_addr = 32'h44;
            mem_req = (c <= 9); mem_we = 0; mem_addr = 32'h100;
            #4;
            total++; if (m_en !== (c % 3 == 0 && c <= 9)) begin bad++; $display("FAIL rr_m_en c=%0d got=%b exp=%b", c, m_en, (c % 3 == 0 && c <= 9)); end
            total++; if (mem_ack !== (c == 3 || c == 9)) begin bad++; $display("FAIL rr_mem_ack c=%0d got=%b exp=%b", c, mem_ack, (c == 3 || c == 9)); end
            total++; if (if_ack !== (c == 6 || c == 12)) begin bad++; $display("FAIL rr_if_ack c=%0d got=%b exp=%b", c, if_ack, (c == 6 || c == 12)); end
            if (c == 0 || c == 6) begin
                total++; if (m_addr !== 32'h100) begin bad++; $display("FAIL rr_addr c=%0d got=%h exp=00000100", c, m_addr); end
            end
            if (c == 3 || c == 9) begin
                total++; if (m_addr !== 32'h44) begin bad++; $display("FAIL rr_addr c=%0d got=%h exp=00000044", c, m_addr); end
            end
            if (c == 12) begin
                total++; if (if_rdata !== 32'h11112222) begin bad++; $display("FAIL rr_if_rdata got=%h exp=11112222", if_rdata); end
            end
            next_cycle();
        end
        idle_inputs();
        next_cycle();
    endtask

    task automatic test_reset_mid_access();
        for (int c = 0; c <= 6; c++) begin
            rst = !(c == 1 || c == 2);
            mem_req = 1; mem_we = 0; mem_addr = 32'h100;
            #4;
            total++; if (mem_ack !== (c == 6)) begin bad++; $display("FAIL rstmid_ack c=%0d got=%b exp=%b", c, mem_ack, (c == 6)); end
            total++; if (m_en !== (c == 0 || c == 3)) begin bad++; $display("FAIL rstmid_m_en c=%0d got=%b exp=%b", c, m_en, (c == 0 || c == 3)); end
            if (c == 2) begin
                total++; if (m_addr !== 32'h0 || m_we !== 1'b0 || m_wdata !== 32'h0) begin bad++; $display("FAIL rstmid_cmd got=%h/%b/%h exp=0/0/0", m_addr, m_we, m_wdata); end
                total++; if (if_rdata !== 32'h0 || mem_rdata !== 32'h0 || if_ack !== 1'b0) begin bad++; $display("FAIL rstmid_out got=%h/%h/%b exp=0/0/0", if_rdata, mem_rdata, if_ack); end
            end
            if (c == 6) begin
                total++; if (mem_rdata !== 32'hA5A50001) begin bad++; $display("FAIL rstmid_rdata got=%h exp=a5a50001", mem_rdata); end
            end
            next_cycle();
        end
        idle_inputs();
        next_cycle();
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst   = 0;
        idle_inputs();
        #1;
        test_reset();
        test_lone_fetch();
        test_simultaneous();
        test_store();
        test_fetch_kill();
        test_back_to_back();
        test_reset_mid_access();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
